demux_1x4_stream: RTL and testbench
===================================

Name: demux_1x4_stream

Overview:
- Inverse of the 4:1 bus mux: one source, four sinks.
- Accepts a word stream on a single valid/ready input, each word tagged with a 2-bit destination, and steers it to one of four output channels.
- Each output channel has its own 2-entry FIFO, so a stalled sink blocks only words addressed to it.
- Sits between a shared producer and four independent consumers on the same BUS_WIDTH datapath.

Parameters:
- BUS_WIDTH, 8, width of every data word (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- s_valid  input  1  input word present.
- s_ready  output  1  block accepts the input word this cycle.
- s_data  input  BUS_WIDTH  input word.
- s_sel  input  2  destination channel, 0..3.
- m_valid  output  4  bit N: channel N head word present.
- m_ready  input  4  bit N: sink N takes the head word this cycle.
- m_data0  output  BUS_WIDTH  channel 0 head word.
- m_data1  output  BUS_WIDTH  channel 1 head word.
- m_data2  output  BUS_WIDTH  channel 2 head word.
- m_data3  output  BUS_WIDTH  channel 3 head word.
- busy  output  1  any channel FIFO non-empty.

Behaviour:
- Reset (rst_n low at a clk edge) clears all FIFO counts, pointers and storage to 0. Reset wins over any same-cycle push or pop.
- After reset: m_valid=4'b0000, m_data0..3=0, busy=0, s_ready=1.
- Reset mid-operation discards all buffered words; nothing already accepted is delivered.
- Per channel state: count (0..2), wr_ptr (1 bit), rd_ptr (1 bit), two BUS_WIDTH entries.
- s_ready = (count[s_sel] != 2). It is combinational from s_sel and registered counts only; no path from m_ready.
- Push: s_valid && s_ready at an edge writes s_data into channel s_sel at wr_ptr, toggles wr_ptr and increments count. Only one channel is written per cycle.
- Pop on channel N: m_valid[N] && m_ready[N] at an edge toggles rd_ptr and decrements count. All four channels may pop in the same cycle.
- m_valid[N] = (count[N] != 0). m_dataN = entry[rd_ptr] of channel N, registered storage, so there is no combinational input-to-output path.
- Latency: a word accepted at edge k gives m_valid and m_data on the destination channel after edge k, and is poppable at edge k+1. Minimum latency is 1 cycle.
- Simultaneous push and pop on the same channel:
  - count 0: not possible, since there is no head to pop.
  - count 1: count stays 1; the head is popped and the new word becomes the head.
  - count 2: s_ready is already 0, so no push occurs, even though a pop frees space in that cycle (no ready pass-through).
- Ordering is FIFO within a channel. There is no ordering guarantee across channels.
- When m_valid[N]=0, m_dataN shows the stale entry at rd_ptr (0 after reset). Sinks must qualify with m_valid.
- Upstream rule: while s_valid=1 and s_ready=0, s_data and s_sel are held stable. The block does not check this; a changed s_sel re-evaluates s_ready against the new channel.
- m_ready[N] asserted while m_valid[N]=0 has no effect.
- busy = OR of (count[N] != 0) over all four channels.
- Width: count is 2 bits saturating in range 0..2 by construction; pointers wrap 1 to 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with s_valid=1 -> m_valid=0000, m_data0..3=0x00, busy=0, s_ready=1, no word stored.
- Single route: send 0xA5 with sel=2, m_ready=1111 -> m_valid=0100 and m_data2=0xA5 one cycle after accept, popped next edge, busy returns to 0.
- Backpressure isolation: m_ready=1110, send 0x11, 0x22, 0x33 to ch0 -> s_ready=0 after the 2nd accept. Then send 0x44 to ch1 -> accepted and delivered while ch0 stays full. Release m_ready[0] -> ch0 delivers 0x11 then 0x22, then accepts 0x33.
- Same-cycle push and pop on ch3 at count=1 (head 0x01, push 0x02, m_ready[3]=1) -> count stays 1, m_data3=0x02 next cycle, 0x01 seen exactly once.
- Full with pop: ch1 count=2, m_ready[1]=1, s_valid=1 with sel=1 -> s_ready=0, no push that cycle, s_ready=1 the following cycle.
- Reset mid-stream: ch0 holds 2 words and ch2 holds 1 word, pulse rst_n=0 for 1 cycle -> all m_valid=0 and busy=0 next cycle, no stale words ever delivered.

Source files
------------

// File: rtl/demux_1x4_stream_if.sv
// Handshake bundle for the 1:4 stream demux: one tagged valid/ready input stream,
// four valid/ready output channels and an activity flag.
interface demux_1x4_stream_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 s_valid;
    logic                 s_ready;
    logic [BUS_WIDTH-1:0] s_data;
    logic [1:0]           s_sel;
    logic [3:0]           m_valid;
    logic [3:0]           m_ready;
    logic [BUS_WIDTH-1:0] m_data0;
    logic [BUS_WIDTH-1:0] m_data1;
    logic [BUS_WIDTH-1:0] m_data2;
    logic [BUS_WIDTH-1:0] m_data3;
    logic                 busy;

    // Producer/consumer side: drives the input stream and the sink readies.
    modport master (
        output s_valid, s_data, s_sel, m_ready,
        input  s_ready, m_valid, m_data0, m_data1, m_data2, m_data3, busy
    );

    // Demux side.
    modport slave (
        input  s_valid, s_data, s_sel, m_ready,
        output s_ready, m_valid, m_data0, m_data1, m_data2, m_data3, busy
    );
endinterface

// File: rtl/demux_1x4_stream.sv
// 1:4 stream demux: each input word is steered by s_sel into one of four
// 2-entry FIFOs, so a stalled sink only blocks words addressed to it.
module demux_1x4_stream #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_1x4_stream_if.slave   bus
);
    logic [1:0]           count [4];
    logic [3:0]           wr_ptr;
    logic [3:0]           rd_ptr;
    logic [BUS_WIDTH-1:0] mem [4][2];

    logic       s_ready_int;
    logic [3:0] valid_vec;
    logic [3:0] push;
    logic [3:0] pop;

    // Ready depends only on registered occupancy of the addressed channel, never on m_ready.
    assign s_ready_int = (count[bus.s_sel] != 2'd2);

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        push      = '0;
        pop       = '0;
        valid_vec = '0;
        for (int n = 0; n < 4; n++) begin
            valid_vec[n] = (count[n] != 2'd0);
            push[n]      = bus.s_valid && s_ready_int && (bus.s_sel == 2'(n));
            pop[n]       = valid_vec[n] && bus.m_ready[n];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // NOTE: storage is cleared too, so heads read as 0 after reset and
            // no word buffered before reset can ever reappear.
            for (int n = 0; n < 4; n++) begin
                count[n] <= 2'd0;
                for (int e = 0; e < 2; e++) begin
                    mem[n][e] <= '0;
                end
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (push[n]) begin
                    mem[n][wr_ptr[n]] <= bus.s_data;
                    wr_ptr[n]         <= ~wr_ptr[n];
                end
                if (pop[n]) begin
                    rd_ptr[n] <= ~rd_ptr[n];
                end
                // Push and pop together leave the count unchanged.
                case ({push[n], pop[n]})
                    2'b10:   count[n] <= count[n] + 2'd1;
                    2'b01:   count[n] <= count[n] - 2'd1;
                    default: count[n] <= count[n];
                endcase
            end
        end
    end

    assign bus.s_ready = s_ready_int;
    assign bus.m_valid = valid_vec;
    assign bus.busy    = |valid_vec;
    assign bus.m_data0 = mem[0][rd_ptr[0]];
    assign bus.m_data1 = mem[1][rd_ptr[1]];
    assign bus.m_data2 = mem[2][rd_ptr[2]];
    assign bus.m_data3 = mem[3][rd_ptr[3]];
endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream: directed scenarios plus a randomized
// run, all compared against per-channel queue models of the four FIFOs.
module tb_demux_1x4_stream;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Model: words buffered per channel, and words delivered to each sink.
    logic [W-1:0] q    [4][$];
    logic [W-1:0] dlog [4][$];

    demux_1x4_stream_if #(.BUS_WIDTH(W)) bus ();

    demux_1x4_stream #(.BUS_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = (q[n].size() != 0);
        return v;
    endfunction

    function automatic logic [W-1:0] dut_data(int n);
        case (n)
            0:       return bus.m_data0;
            1:       return bus.m_data1;
            2:       return bus.m_data2;
            default: return bus.m_data3;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                         input logic [3:0] rdy);
        bus.s_valid = v;
        bus.s_sel   = sel;
        bus.s_data  = d;
        bus.m_ready = rdy;
        #1;
    endtask

    // Advance one clock edge and update the model from the FIFO rules.
    task automatic tick();
        logic       acc;
        logic [3:0] pops;
        logic [1:0] sel;
        logic [W-1:0] d;
        sel = bus.s_sel;
        d   = bus.s_data;
        acc = bus.s_valid && (q[sel].size() < 2);
        for (int n = 0; n < 4; n++) pops[n] = bus.m_ready[n] && (q[n].size() > 0);
        @(posedge clk);
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) q[n].delete();
        end else begin
            for (int n = 0; n < 4; n++)
                if (pops[n]) dlog[n].push_back(q[n].pop_front());
            if (acc) q[sel].push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        for (int n = 0; n < 4; n++) dlog[n].delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 2'd0, 8'hFF, 4'b0000);
        tick();
        tick();
        checks++; if (bus.m_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", bus.m_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.s_ready); end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (dut_data(n) !== '0) begin errors++; $display("FAIL reset_data%0d: got %h expected 00", n, dut_data(n)); end
        end
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        tick();
        checks++; if (bus.m_valid !== 4'b0000) begin errors++; $display("FAIL reset_nostore: got %b expected 0000", bus.m_valid); end
    endtask

    task automatic test_single_route();
        clear_logs();
        drive(1'b1, 2'd2, 8'hA5, 4'b1111);
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL route_ready: got %b expected 1", bus.s_ready); end
        tick();
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        checks++; if (bus.m_valid !== 4'b0100) begin errors++; $display("FAIL route_valid: got %b expected 0100", bus.m_valid); end
        checks++; if (bus.m_data2 !== 8'hA5) begin errors++; $display("FAIL route_data: got %h expected a5", bus.m_data2); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL route_busy: got %b expected 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.m_valid !== 4'b0000) begin errors++; $display("FAIL route_drain: got busy %b valid %b expected 0 0000", bus.busy, bus.m_valid); end
        checks++; if (dlog[2].size() != 1 || dlog[2][0] !== 8'hA5) begin errors++; $display("FAIL route_delivered: got %0d words expected 1 word a5", dlog[2].size()); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp0 [3];
        exp0[0] = 8'h11; exp0[1] = 8'h22; exp0[2] = 8'h33;
        clear_logs();
        drive(1'b1, 2'd0, 8'h11, 4'b1110); tick();
        drive(1'b1, 2'd0, 8'h22, 4'b1110); tick();
        drive(1'b1, 2'd0, 8'h33, 4'b1110);
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", bus.s_ready); end
        tick();
        drive(1'b1, 2'd1, 8'h44, 4'b1110);
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_ch1_ready: got %b expected 1", bus.s_ready); end
        tick();
        drive(1'b0, 2'd0, 8'h00, 4'b1110);
        checks++; if (bus.m_valid !== 4'b0011 || bus.m_data1 !== 8'h44 || bus.m_data0 !== 8'h11) begin errors++; $display("FAIL bp_isolation: got valid %b d0 %h d1 %h expected 0011 11 44", bus.m_valid, bus.m_data0, bus.m_data1); end
        tick();
        drive(1'b1, 2'd0, 8'h33, 4'b1111);
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %b expected 0", bus.s_ready); end
        tick();
        drive(1'b1, 2'd0, 8'h33, 4'b1111);
        checks++; if (bus.s_ready !== 1'b1 || bus.m_data0 !== 8'h22) begin errors++; $display("FAIL bp_release: got ready %b d0 %h expected 1 22", bus.s_ready, bus.m_data0); end
        tick();
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        tick();
        checks++; if (dlog[0].size() != 3) begin errors++; $display("FAIL bp_ch0_count: got %0d expected 3", dlog[0].size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (dlog[0][i] !== exp0[i]) begin errors++; $display("FAIL bp_ch0_order%0d: got %h expected %h", i, dlog[0][i], exp0[i]); end
        end
        checks++; if (dlog[1].size() != 1 || dlog[1][0] !== 8'h44) begin errors++; $display("FAIL bp_ch1_word: got %0d words expected 1 word 44", dlog[1].size()); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_same_cycle();
        clear_logs();
        drive(1'b1, 2'd3, 8'h01, 4'b0000); tick();
        drive(1'b1, 2'd3, 8'h02, 4'b1000);
        checks++; if (bus.s_ready !== 1'b1 || bus.m_data3 !== 8'h01) begin errors++; $display("FAIL same_pre: got ready %b d3 %h expected 1 01", bus.s_ready, bus.m_data3); end
        tick();
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        checks++; if (bus.m_valid !== 4'b1000 || bus.m_data3 !== 8'h02) begin errors++; $display("FAIL same_head: got valid %b d3 %h expected 1000 02", bus.m_valid, bus.m_data3); end
        drive(1'b0, 2'd0, 8'h00, 4'b1000); tick();
        checks++; if (dlog[3].size() != 2 || dlog[3][0] !== 8'h01 || dlog[3][1] !== 8'h02) begin errors++; $display("FAIL same_delivered: got %0d words expected 01 02", dlog[3].size()); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL same_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_full_pop();
        clear_logs();
        drive(1'b1, 2'd1, 8'h5A, 4'b0000); tick();
        drive(1'b1, 2'd1, 8'hC3, 4'b0000); tick();
        drive(1'b1, 2'd1, 8'h77, 4'b0010);
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b expected 0", bus.s_ready); end
        tick();
        drive(1'b1, 2'd1, 8'h77, 4'b0000);
        checks++; if (bus.s_ready !== 1'b1 || bus.m_data1 !== 8'hC3) begin errors++; $display("FAIL full_pop_after: got ready %b d1 %h expected 1 c3", bus.s_ready, bus.m_data1); end
        drive(1'b0, 2'd0, 8'h00, 4'b0010); tick(); tick();
        checks++; if (dlog[1].size() != 2 || dlog[1][0] !== 8'h5A || dlog[1][1] !== 8'hC3) begin errors++; $display("FAIL full_pop_words: got %0d words expected 5a c3", dlog[1].size()); end
        checks++; if (bus.m_valid !== 4'b0000) begin errors++; $display("FAIL full_pop_empty: got %b expected 0000", bus.m_valid); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        drive(1'b1, 2'd0, 8'hD1, 4'b0000); tick();
        drive(1'b1, 2'd0, 8'hD2, 4'b0000); tick();
        drive(1'b1, 2'd2, 8'hE1, 4'b0000); tick();
        checks++; if (bus.m_valid !== 4'b0101) begin errors++; $display("FAIL mid_loaded: got %b expected 0101", bus.m_valid); end
        rst_n = 1'b0;
        drive(1'b1, 2'd0, 8'hEE, 4'b1111); tick();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        checks++; if (bus.m_valid !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_cleared: got valid %b busy %b expected 0000 0", bus.m_valid, bus.busy); end
        checks++; if (bus.m_data0 !== 8'h00 || bus.m_data2 !== 8'h00) begin errors++; $display("FAIL mid_storage: got d0 %h d2 %h expected 00 00", bus.m_data0, bus.m_data2); end
        for (int i = 0; i < 3; i++) tick();
        for (int n = 0; n < 4; n++) begin
            checks++; if (dlog[n].size() != 0) begin errors++; $display("FAIL mid_stale%0d: got %0d words expected 0", n, dlog[n].size()); end
        end
    endtask

    task automatic test_random();
        logic [3:0] ev;
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
            ev = exp_valid();
            checks++; if (bus.s_ready !== (q[bus.s_sel].size() < 2)) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.s_ready, q[bus.s_sel].size() < 2); end
            checks++; if (bus.m_valid !== ev || bus.busy !== (|ev)) begin errors++; $display("FAIL rand_valid c%0d: got %b/%b expected %b/%b", c, bus.m_valid, bus.busy, ev, |ev); end
            for (int n = 0; n < 4; n++) if (ev[n]) begin
                checks++; if (dut_data(n) !== q[n][0]) begin errors++; $display("FAIL rand_data%0d c%0d: got %h expected %h", n, c, dut_data(n), q[n][0]); end
            end
            tick();
        end
        drive(1'b0, 2'd0, 8'h00, 4'b1111);
        tick(); tick();
        checks++; if (bus.m_valid !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL rand_drain: got valid %b busy %b expected 0000 0", bus.m_valid, bus.busy); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_sel   = 2'd0;
        bus.s_data  = '0;
        bus.m_ready = 4'b0000;
        @(negedge clk);
        test_reset();
        test_single_route();
        test_backpressure();
        test_same_cycle();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
